// File: rtl/ddr_pkg.sv
// Shared DDR read-path constants and types.
package ddr_pkg;

  localparam int DATA_SIZE = 64;
  localparam int TID_SIZE  = 2;
  localparam int BURST_LEN = 4;
  // A RAW burst needs this many tail stages of the delay line empty so it can finish before DRAM data lands.
  localparam int RAW_GUARD = 5;

  typedef logic [TID_SIZE-1:0]  tid_t;
  typedef logic [DATA_SIZE-1:0] beat_t;

endpackage

// File: rtl/rl_delay_line.sv
// Read-latency pipeline: carries valid+tid of each issued DRAM read for RL cycles, exposing per-stage occupancy.
module rl_delay_line import ddr_pkg::*; #(
  parameter int TID_SIZE = ddr_pkg::TID_SIZE,
  parameter int RL       = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                vld_i,
  input  logic [TID_SIZE-1:0] tid_i,
  output logic [RL-1:0]       stage_vld_o,
  output logic [TID_SIZE-1:0] tid_o
);

  logic [RL-1:0]       vld_q;
  logic [TID_SIZE-1:0] tid_q [RL];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_q <= '0;
      for (int i = 0; i < RL; i++) tid_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[RL-2:0], vld_i};
      tid_q[0] <= tid_i;
      for (int i = 1; i < RL; i++) tid_q[i] <= tid_q[i-1];
    end
  end

  assign stage_vld_o = vld_q;
  assign tid_o       = tid_q[RL-1];

endmodule

// File: rtl/read_return_ctrl.sv
// Read-return controller: merges DRAM read bursts and write-buffer forwarded bursts onto one beat port.
// Forwarding path is built only when RAW_FWD_EN is defined.
//   state      | meaning
//   IDLE       | no beat on the output
//   DRAM_BURST | output carries DRAM beat beat_q
//   RAW_BURST  | output carries forwarded beat beat_q
module read_return_ctrl import ddr_pkg::*; #(
  parameter int DATA_SIZE = ddr_pkg::DATA_SIZE,
  parameter int TID_SIZE  = ddr_pkg::TID_SIZE,
  parameter int DEPTH     = 4,
  parameter int RL        = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           rd_issue,
  input  logic [TID_SIZE-1:0]            rd_tid,
  input  logic                           raw_hit,
  input  logic [BURST_LEN*DATA_SIZE-1:0] raw_data,
  input  logic [DATA_SIZE-1:0]           dq_in,
  output logic [DATA_SIZE-1:0]           mux_data,
  output logic                           strobe,
  output logic                           raw_strobe,
  output logic [TID_SIZE-1:0]            tid_pop,
  output logic                           full,
  output logic                           err
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DRAM_BURST = 2'd1;
  localparam logic [1:0] RAW_BURST  = 2'd2;
  localparam logic [1:0] LAST_BEAT  = 2'(BURST_LEN - 1);
  localparam logic [1:0] PEN_BEAT   = 2'(BURST_LEN - 2);
  localparam int         CW         = $clog2(DEPTH + 1);

  logic [1:0]          state_q, state_d, beat_q, beat_d;
  logic [DATA_SIZE-1:0] mux_q, mux_d;
  logic                strobe_q, strobe_d, raw_strobe_q, raw_strobe_d;
  logic [TID_SIZE-1:0] tid_q, tid_d;
  logic [CW-1:0]       out_q, out_d;
  logic                full_q, err_q;

  logic [RL-1:0]       stage_vld;
  logic [TID_SIZE-1:0] stage_tid;
  logic                dram_push, raw_push, drop, raw_start;
  logic                emerge, busy_dram, busy_raw, dram_start, discard, last_beat, hold_free, tail_busy;
  logic                hold_v_q;
  logic [TID_SIZE-1:0] hold_tid_q;
  logic [BURST_LEN*DATA_SIZE-1:0] hold_data_q;
  logic                unused_stages;

  rl_delay_line #(.TID_SIZE(TID_SIZE), .RL(RL)) u_rl_delay_line (
    .clk         (clk),
    .n_rst       (n_rst),
    .vld_i       (dram_push),
    .tid_i       (rd_tid),
    .stage_vld_o (stage_vld),
    .tid_o       (stage_tid)
  );

  assign unused_stages = ^stage_vld;
  assign tail_busy     = |stage_vld[RL-1 -: RAW_GUARD];
  assign emerge        = stage_vld[RL-1];
  assign busy_dram     = (state_q == DRAM_BURST) && (beat_q != LAST_BEAT);
  assign busy_raw      = (state_q == RAW_BURST) && (beat_q != LAST_BEAT);
  assign dram_start    = emerge & ~busy_dram;
  assign discard       = emerge & busy_dram;
  assign last_beat     = (busy_dram | busy_raw) && (beat_q == PEN_BEAT);
  assign hold_free     = busy_raw && (beat_q == PEN_BEAT);

`ifdef RAW_FWD_EN
  // rd_issue together with raw_hit is served from the write buffer, never from DRAM.
  assign raw_push  = raw_hit & ~full_q & ~hold_v_q;
  assign dram_push = rd_issue & ~raw_hit & ~full_q;
  assign drop      = (rd_issue | raw_hit) & ~(raw_push | dram_push);
  assign raw_start = hold_v_q && (state_q == IDLE) && !tail_busy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_v_q    <= 1'b0;
      hold_tid_q  <= '0;
      hold_data_q <= '0;
    end else if (raw_push) begin
      hold_v_q    <= 1'b1;
      hold_tid_q  <= rd_tid;
      hold_data_q <= raw_data;
    end else if (hold_free) begin
      hold_v_q    <= 1'b0;
    end
  end
`else
  logic unused_raw;
  assign unused_raw  = ^{raw_hit, raw_data, hold_free, tail_busy};
  assign raw_push    = 1'b0;
  assign dram_push   = rd_issue & ~full_q;
  assign drop        = rd_issue & full_q;
  assign raw_start   = 1'b0;
  assign hold_v_q    = 1'b0;
  assign hold_tid_q  = '0;
  assign hold_data_q = '0;
`endif

  always_comb begin
    state_d      = IDLE;
    beat_d       = '0;
    mux_d        = '0;
    strobe_d     = 1'b0;
    raw_strobe_d = 1'b0;
    tid_d        = '0;
    if (busy_dram) begin
      state_d  = DRAM_BURST;
      beat_d   = beat_q + 2'd1;
      mux_d    = dq_in;
      strobe_d = 1'b1;
      tid_d    = tid_q;
    end else if (dram_start) begin
      state_d  = DRAM_BURST;
      mux_d    = dq_in;
      strobe_d = 1'b1;
      tid_d    = stage_tid;
    end else if (busy_raw) begin
      state_d      = RAW_BURST;
      beat_d       = beat_q + 2'd1;
      mux_d        = hold_data_q[int'(beat_d)*DATA_SIZE +: DATA_SIZE];
      raw_strobe_d = 1'b1;
      tid_d        = tid_q;
    end else if (raw_start) begin
      state_d      = RAW_BURST;
      mux_d        = hold_data_q[DATA_SIZE-1:0];
      raw_strobe_d = 1'b1;
      tid_d        = hold_tid_q;
    end
  end

  // A discarded delay-line entry retires just like a completed burst.
  assign out_d = out_q + CW'(dram_push | raw_push) - CW'(last_beat) - CW'(discard);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      mux_q        <= '0;
      strobe_q     <= 1'b0;
      raw_strobe_q <= 1'b0;
      tid_q        <= '0;
      out_q        <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      mux_q        <= mux_d;
      strobe_q     <= strobe_d;
      raw_strobe_q <= raw_strobe_d;
      tid_q        <= tid_d;
      out_q        <= out_d;
      full_q       <= (out_d == CW'(DEPTH));
      err_q        <= drop | discard;
    end
  end

  assign mux_data   = mux_q;
  assign strobe     = strobe_q;
  assign raw_strobe = raw_strobe_q;
  assign tid_pop    = tid_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_read_return_ctrl.sv
// Directed bench for read_return_ctrl: u_dut uses RL=8; u_deep (RL=16) shares the inputs for the depth/full test.
module tb_read_return_ctrl;

  logic         clk = 1'b0;
  logic         n_rst, rd_issue, raw_hit;
  logic [1:0]   rd_tid;
  logic [255:0] raw_data;
  logic [63:0]  dq_in;
  logic [63:0]  mux_data, d_mux_data;
  logic         strobe, raw_strobe, full, err;
  logic         d_strobe, d_raw_strobe, d_full, d_err;
  logic [1:0]   tid_pop, d_tid_pop;
  logic         e_s, e_rs;
  logic [1:0]   e_tid;
  logic [63:0]  e_mux;
  int           n_err = 0;
  int           n_checks = 0;
  int           beats;

  always #5 clk = ~clk;

  read_return_ctrl #(.DATA_SIZE(64), .TID_SIZE(2), .DEPTH(4), .RL(8)) u_dut (
    .clk(clk), .n_rst(n_rst), .rd_issue(rd_issue), .rd_tid(rd_tid), .raw_hit(raw_hit),
    .raw_data(raw_data), .dq_in(dq_in), .mux_data(mux_data), .strobe(strobe),
    .raw_strobe(raw_strobe), .tid_pop(tid_pop), .full(full), .err(err)
  );

  read_return_ctrl #(.DATA_SIZE(64), .TID_SIZE(2), .DEPTH(4), .RL(16)) u_deep (
    .clk(clk), .n_rst(n_rst), .rd_issue(rd_issue), .rd_tid(rd_tid), .raw_hit(raw_hit),
    .raw_data(raw_data), .dq_in(dq_in), .mux_data(d_mux_data), .strobe(d_strobe),
    .raw_strobe(d_raw_strobe), .tid_pop(d_tid_pop), .full(d_full), .err(d_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    n_rst    = 1'b0;
    rd_issue = 1'b0;
    raw_hit  = 1'b0;
    rd_tid   = 2'd0;
    raw_data = '0;
    dq_in    = '0;
    next_cycle();
    next_cycle();
    n_rst = 1'b1;
    next_cycle();
  endtask

  // Checks the u_dut beat outputs against e_s / e_rs / e_mux / e_tid.
  task automatic chk_beat(input string tag);
    chk({tag, "_strobe"}, 64'(strobe), 64'(e_s));
    chk({tag, "_raw_strobe"}, 64'(raw_strobe), 64'(e_rs));
    chk({tag, "_mux"}, mux_data, e_mux);
    chk({tag, "_overlap"}, 64'(strobe & raw_strobe), 64'd0);
    if (e_s | e_rs) chk({tag, "_tid"}, 64'(tid_pop), 64'(e_tid));
  endtask

  initial begin
    n_rst    = 1'b0;
    rd_issue = 1'b0;
    raw_hit  = 1'b0;
    rd_tid   = 2'd0;
    raw_data = '0;
    dq_in    = 64'hFFFF;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mux", mux_data, 64'd0);
    chk("rst_strobe", 64'(strobe), 64'd0);
    chk("rst_raw_strobe", 64'(raw_strobe), 64'd0);
    chk("rst_tid", 64'(tid_pop), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Single DRAM read, tid 1, data 0x11..0x44 at T+8..T+11.
    apply_reset();
    for (int i = 0; i <= 14; i++) begin
      rd_issue = (i == 0);
      rd_tid   = 2'd1;
      dq_in    = (i >= 8 && i <= 11) ? 64'(32'h11 * (i - 7)) : 64'hDEAD;
      @(negedge clk);
      e_s   = (i >= 9 && i <= 12);
      e_rs  = 1'b0;
      e_mux = e_s ? 64'(32'h11 * (i - 8)) : 64'd0;
      e_tid = 2'd1;
      chk_beat("dram1");
      chk("dram1_err", 64'(err), 64'd0);
      next_cycle();
    end

    // rd_issue with raw_hit while idle, tid 2, beats 5..8.
    apply_reset();
    for (int i = 0; i <= 13; i++) begin
      rd_issue = (i == 0);
      raw_hit  = (i == 0);
      rd_tid   = 2'd2;
      raw_data = (i == 0) ? {64'd8, 64'd7, 64'd6, 64'd5} : '0;
      dq_in    = 64'(32'hA0 + i);
      @(negedge clk);
`ifdef RAW_FWD_EN
      e_s   = 1'b0;
      e_rs  = (i >= 2 && i <= 5);
      e_mux = e_rs ? 64'(i + 3) : 64'd0;
`else
      e_s   = (i >= 9 && i <= 12);
      e_rs  = 1'b0;
      e_mux = e_s ? 64'(32'hA0 + i - 1) : 64'd0;
`endif
      e_tid = 2'd2;
      chk_beat("raw1");
      next_cycle();
    end

    // RAW request while a DRAM entry sits 3 stages from the output: RAW waits for the DRAM burst.
    apply_reset();
    for (int i = 0; i <= 20; i++) begin
      rd_issue = (i == 0);
      raw_hit  = (i == 5);
      rd_tid   = (i == 5) ? 2'd3 : 2'd1;
      raw_data = (i == 5) ? {64'h0D, 64'h0C, 64'h0B, 64'h0A} : '0;
      dq_in    = 64'(32'h50 + i);
      @(negedge clk);
      e_s = (i >= 9 && i <= 12);
`ifdef RAW_FWD_EN
      e_rs = (i >= 14 && i <= 17);
`else
      e_rs = 1'b0;
`endif
      e_mux = e_s ? 64'(32'h50 + i - 1) : (e_rs ? 64'(32'h0A + i - 14) : 64'd0);
      e_tid = e_s ? 2'd1 : 2'd3;
      chk_beat("rawwait");
      next_cycle();
    end

    // Two reads two cycles apart: second collides with the first burst and is discarded.
    apply_reset();
    for (int i = 0; i <= 16; i++) begin
      rd_issue = (i == 0 || i == 2);
      rd_tid   = (i == 2) ? 2'd2 : 2'd1;
      dq_in    = 64'(32'h60 + i);
      @(negedge clk);
      e_s   = (i >= 9 && i <= 12);
      e_rs  = 1'b0;
      e_mux = e_s ? 64'(32'h60 + i - 1) : 64'd0;
      e_tid = 2'd1;
      chk_beat("collide");
      chk("collide_err", 64'(err), 64'(i == 11));
      next_cycle();
    end

    // Depth test on u_deep (RL=16): four reads fill it, the fifth is dropped.
    apply_reset();
    beats = 0;
    for (int i = 0; i <= 40; i++) begin
      rd_issue = (i % 4 == 0) && (i <= 16);
      rd_tid   = (i == 16) ? 2'd3 : 2'(i / 4);
      dq_in    = 64'(32'h70 + i);
      @(negedge clk);
      if (d_strobe) beats++;
      chk("depth_full", 64'(d_full), 64'(i >= 13 && i <= 19));
      chk("depth_err", 64'(d_err), 64'(i == 17));
      chk("depth_strobe", 64'(d_strobe), 64'(i >= 17 && i <= 32));
      chk("depth_mux", d_mux_data, (i >= 17 && i <= 32) ? 64'(32'h70 + i - 1) : 64'd0);
      if (i >= 17 && i <= 32) chk("depth_tid", 64'(d_tid_pop), 64'((i - 17) / 4));
      next_cycle();
    end
    chk("depth_beats", 64'(beats), 64'd16);

    // Reset asserted while beat 2 of a DRAM burst is on the output.
    apply_reset();
    for (int i = 0; i <= 24; i++) begin
      rd_issue = (i == 0);
      rd_tid   = 2'd3;
      dq_in    = 64'(32'h80 + i);
      if (i == 12) n_rst = 1'b1;
      @(negedge clk);
      if (i == 11) begin
        chk("rstmid_beat2_strobe", 64'(strobe), 64'd1);
        chk("rstmid_beat2_mux", mux_data, 64'h8A);
        n_rst = 1'b0;
        #1;
        chk("rstmid_mux", mux_data, 64'd0);
        chk("rstmid_strobe", 64'(strobe), 64'd0);
        chk("rstmid_tid", 64'(tid_pop), 64'd0);
        chk("rstmid_full", 64'(full), 64'd0);
        chk("rstmid_err", 64'(err), 64'd0);
      end else if (i >= 12) begin
        chk("rstmid_after_strobe", 64'(strobe), 64'd0);
        chk("rstmid_after_raw", 64'(raw_strobe), 64'd0);
        chk("rstmid_after_mux", mux_data, 64'd0);
        chk("rstmid_after_full", 64'(full), 64'd0);
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
